// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and constants for sprite_overlay_engine
// Optional feature macro: SPRITE_ANIM_EN (adds per-sprite animation fields).
package sprite_pkg;

    // Register fields are stored at fixed widths; the engine uses only the
    // low COORD_W / IMG_W bits of each.
    localparam int SP_FIELD_W     = 16;
    localparam int SP_IMG_FIELD_W = 8;

    // Register select, low two bits of address_i.
    localparam logic [1:0] REG_X    = 2'd0;
    localparam logic [1:0] REG_Y    = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;

    localparam logic [23:0] DEFAULT_TRANSPARENT_KEY = 24'hFF00FF;

    typedef struct packed {
        logic [SP_FIELD_W-1:0]     x;
        logic [SP_FIELD_W-1:0]     y;
        logic                      en;
        logic [SP_IMG_FIELD_W-1:0] img;
`ifdef SPRITE_ANIM_EN
        logic [3:0]                frames;
        logic [3:0]                div;
        logic [3:0]                anim;
`endif
    } sprite_regs_t;

endpackage

// File: rtl/sprite_hit.sv
// rtl/sprite_hit.sv - window compare and local texel offset for one sprite channel
// Ports:
//   x_pos, y_pos   current scan pixel
//   x0, y0         sprite top-left corner (active registers)
//   en             sprite enable
//   hit            pixel lies inside the enabled sprite window
//   off_x, off_y   pixel offset inside the sprite (valid when hit)
module sprite_hit #(
    parameter int COORD_W     = 11,
    parameter int SPRITE_SIZE = 32
) (
    input  logic [COORD_W-1:0]             x_pos,
    input  logic [COORD_W-1:0]             y_pos,
    input  logic [COORD_W-1:0]             x0,
    input  logic [COORD_W-1:0]             y0,
    input  logic                           en,
    output logic                           hit,
    output logic [$clog2(SPRITE_SIZE)-1:0] off_x,
    output logic [$clog2(SPRITE_SIZE)-1:0] off_y
);

    localparam int OFF_W = $clog2(SPRITE_SIZE);
    localparam logic [COORD_W:0] SIZE_EXT = (COORD_W+1)'(SPRITE_SIZE);

    // One extra bit so a window near the right/bottom edge never wraps to 0.
    logic [COORD_W:0] xe, ye, x0e, y0e, dx, dy;
    logic             in_x, in_y;
    logic             unused_hi;

    assign xe  = {1'b0, x_pos};
    assign ye  = {1'b0, y_pos};
    assign x0e = {1'b0, x0};
    assign y0e = {1'b0, y0};

    assign in_x = (xe >= x0e) && (xe < (x0e + SIZE_EXT));
    assign in_y = (ye >= y0e) && (ye < (y0e + SIZE_EXT));
    assign hit  = en && in_x && in_y;

    assign dx    = xe - x0e;
    assign dy    = ye - y0e;
    assign off_x = dx[OFF_W-1:0];
    assign off_y = dy[OFF_W-1:0];

    assign unused_hi = ^{dx[COORD_W:OFF_W], dy[COORD_W:OFF_W]};

endmodule

// File: rtl/sprite_overlay_engine.sv
// rtl/sprite_overlay_engine.sv - multi-channel sprite compositor with shared sprite ROM
// Optional feature macro: SPRITE_ANIM_EN (ctrl[11:8] frame count, ctrl[15:12] divider).
// Ports:
//   clk, rst_n            pixel clock, asynchronous active-low reset
//   MW_i, address_i,      register write: address_i = {sprite index, reg sel}
//   data_i
//   frame_start_i         commits shadow registers to active registers
//   x_pos_i, y_pos_i,     scan pixel and its background colour
//   bg_rgb_i
//   mem_address_o         sprite ROM address (stage 1)
//   mem_data_i            ROM texel for mem_address_o, consumed in stage 2
//   RGB_o, hit_o          composited pixel, opaque-sprite flag (stage 2)
module sprite_overlay_engine
    import sprite_pkg::*;
#(
    parameter int          NUM_SPRITES     = 4,
    parameter int          SPRITE_SIZE     = 32,
    parameter int          COORD_W         = 11,
    parameter int          MEM_ADDR_W      = 16,
    parameter int          IMG_W           = 4,
    parameter logic [23:0] TRANSPARENT_KEY = DEFAULT_TRANSPARENT_KEY
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             MW_i,
    input  logic [$clog2(NUM_SPRITES)+1:0]   address_i,
    input  logic [31:0]                      data_i,
    input  logic                             frame_start_i,
    input  logic [COORD_W-1:0]               x_pos_i,
    input  logic [COORD_W-1:0]               y_pos_i,
    input  logic [23:0]                      bg_rgb_i,
    output logic [MEM_ADDR_W-1:0]            mem_address_o,
    input  logic [23:0]                      mem_data_i,
    output logic [23:0]                      RGB_o,
    output logic                             hit_o
);

    localparam int AW    = $clog2(NUM_SPRITES) + 2;
    localparam int OFF_W = $clog2(SPRITE_SIZE);

    sprite_regs_t shadow     [NUM_SPRITES];
    sprite_regs_t shadow_nxt [NUM_SPRITES];
    sprite_regs_t active     [NUM_SPRITES];
    sprite_regs_t active_nxt [NUM_SPRITES];

    logic [NUM_SPRITES-1:0]    hit_vec;
    logic [OFF_W-1:0]          off_x   [NUM_SPRITES];
    logic [OFF_W-1:0]          off_y   [NUM_SPRITES];
    logic [SP_IMG_FIELD_W-1:0] img_eff [NUM_SPRITES];

    logic                      win_any;
    logic [SP_IMG_FIELD_W-1:0] win_img;
    logic [OFF_W-1:0]          win_ox, win_oy;
    logic [31:0]               addr_full;
    logic [MEM_ADDR_W-1:0]     addr_nxt;

    logic                      win_valid;
    logic [23:0]               bg_d1;

    logic                      unused_data;
    logic                      unused_addr;
    logic [NUM_SPRITES-1:0]    unused_act;

`ifdef SPRITE_ANIM_EN
    logic [NUM_SPRITES-1:0]    ctrl_wr;
    logic [NUM_SPRITES-1:0]    ctrl_pend;
    logic [3:0]                div_cnt [NUM_SPRITES];
    logic [3:0]                div_nxt [NUM_SPRITES];
`endif

    // ------------------------------------------------------------------
    // Register write decode into the shadow set
    // ------------------------------------------------------------------
    always_comb begin
        shadow_nxt = shadow;
`ifdef SPRITE_ANIM_EN
        ctrl_wr = '0;
`endif
        if (MW_i) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if ((address_i >> 2) == AW'(i)) begin
                    case (address_i[1:0])
                        REG_X: shadow_nxt[i].x = SP_FIELD_W'(data_i[COORD_W-1:0]);
                        REG_Y: shadow_nxt[i].y = SP_FIELD_W'(data_i[COORD_W-1:0]);
                        REG_CTRL: begin
                            shadow_nxt[i].en  = data_i[0];
                            shadow_nxt[i].img = SP_IMG_FIELD_W'(data_i[IMG_W+3:4]);
`ifdef SPRITE_ANIM_EN
                            shadow_nxt[i].frames = data_i[11:8];
                            shadow_nxt[i].div    = data_i[15:12];
                            ctrl_wr[i]           = 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Commit values: shadow (including a same-cycle write), plus the
    // animation step when enabled
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            active_nxt[i] = shadow_nxt[i];
`ifdef SPRITE_ANIM_EN
            div_nxt[i] = div_cnt[i];
            if (ctrl_pend[i] || ctrl_wr[i]) begin
                // A freshly written ctrl restarts its animation.
                active_nxt[i].anim = 4'd0;
                div_nxt[i]         = 4'd0;
            end else if (active[i].frames == 4'd0) begin
                active_nxt[i].anim = 4'd0;
                div_nxt[i]         = 4'd0;
            end else if (div_cnt[i] == active[i].div) begin
                div_nxt[i] = 4'd0;
                if ((active[i].anim + 4'd1) >= active[i].frames)
                    active_nxt[i].anim = 4'd0;
                else
                    active_nxt[i].anim = active[i].anim + 4'd1;
            end else begin
                active_nxt[i].anim = active[i].anim;
                div_nxt[i]         = div_cnt[i] + 4'd1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            shadow <= shadow_nxt;
            if (frame_start_i)
                active <= active_nxt;
        end
    end

`ifdef SPRITE_ANIM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_pend <= '0;
            for (int i = 0; i < NUM_SPRITES; i++)
                div_cnt[i] <= 4'd0;
        end else if (frame_start_i) begin
            ctrl_pend <= '0;
            div_cnt   <= div_nxt;
        end else begin
            ctrl_pend <= ctrl_pend | ctrl_wr;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Per-channel window test on the active set
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_chan
        sprite_hit #(
            .COORD_W     (COORD_W),
            .SPRITE_SIZE (SPRITE_SIZE)
        ) u_hit (
            .x_pos (x_pos_i),
            .y_pos (y_pos_i),
            .x0    (active[g].x[COORD_W-1:0]),
            .y0    (active[g].y[COORD_W-1:0]),
            .en    (active[g].en),
            .hit   (hit_vec[g]),
            .off_x (off_x[g]),
            .off_y (off_y[g])
        );

`ifdef SPRITE_ANIM_EN
        assign img_eff[g] = active[g].img + SP_IMG_FIELD_W'(active[g].anim);
`else
        assign img_eff[g] = active[g].img;
`endif
        assign unused_act[g] = ^active[g];
    end

    // ------------------------------------------------------------------
    // Priority select: scanning downward lets the lowest index win, so a
    // single ROM address is formed for the pixel.
    // ------------------------------------------------------------------
    always_comb begin
        win_any = 1'b0;
        win_img = '0;
        win_ox  = '0;
        win_oy  = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                win_any = 1'b1;
                win_img = img_eff[i];
                win_ox  = off_x[i];
                win_oy  = off_y[i];
            end
        end
        addr_full = 32'(win_img) * 32'(SPRITE_SIZE * SPRITE_SIZE)
                  + 32'(win_oy)  * 32'(SPRITE_SIZE)
                  + 32'(win_ox);
        addr_nxt  = win_any ? MEM_ADDR_W'(addr_full) : '0;
    end

    // Stage 1: ROM address, winner-valid and aligned background.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_address_o <= '0;
            win_valid     <= 1'b0;
            bg_d1         <= '0;
        end else begin
            mem_address_o <= addr_nxt;
            win_valid     <= win_any;
            bg_d1         <= bg_rgb_i;
        end
    end

    // Stage 2: a transparent texel shows background, never a lower sprite.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RGB_o <= '0;
            hit_o <= 1'b0;
        end else if (win_valid && (mem_data_i != TRANSPARENT_KEY)) begin
            RGB_o <= mem_data_i;
            hit_o <= 1'b1;
        end else begin
            RGB_o <= bg_d1;
            hit_o <= 1'b0;
        end
    end

    assign unused_data = ^data_i;
    assign unused_addr = ^addr_full;

endmodule

// File: doc/sprite_overlay_engine.md
# sprite_overlay_engine

Multi-channel sprite compositor for the graphic controller: holds position/control registers for `NUM_SPRITES` sprites, tests each scan pixel against every sprite window, and fetches the winning sprite's texel from a shared synchronous sprite ROM. Opaque texels replace the background; texels matching a transparency key pass the background through. The block sits between the VGA timing generator (pixel coordinates, frame start) and the final RGB output mux. Register writes come from the CPU-side memory-write path and are double-buffered so that no sprite tears mid-frame.

## Interface
- `NUM_SPRITES`, 4, number of sprite channels (1–16)
- `SPRITE_SIZE`, 32, sprite edge in pixels (power of two)
- `COORD_W`, 11, pixel coordinate width
- `MEM_ADDR_W`, 16, sprite ROM address width
- `IMG_W`, 4, image-index field width
- `TRANSPARENT_KEY`, 24'hFF00FF, texel value treated as transparent
- `clk  in  1`  pixel clock
- `rst_n  in  1`  reset, asynchronous, active-low
- `MW_i  in  1`  register write strobe
- `address_i  in  $clog2(NUM_SPRITES)+2`  {sprite index, reg sel}
- `data_i  in  32`  write data
- `frame_start_i  in  1`  one-cycle pulse at start of frame
- `x_pos_i, y_pos_i  in  COORD_W`  current scan pixel
- `bg_rgb_i  in  24`  background pixel, aligned with coordinates
- `mem_address_o  out  MEM_ADDR_W`  sprite ROM address
- `mem_data_i  in  24`  ROM data, valid one cycle after address
- `RGB_o  out  24`  composited pixel
- `hit_o  out  1`  an opaque sprite texel drove `RGB_o`

## Operation
- Register select (low 2 bits): 0 = x (top-left), 1 = y (top-left), 2 = ctrl (bit0 enable, bits[IMG_W+3:4] image index), 3 = ignored.
- Writes land in shadow registers on the rising edge with `MW_i`=1. On `frame_start_i`, all shadows copy to active registers. A write in the same cycle as `frame_start_i` is included in the commit.
- Hit test per sprite, using active registers only: enable & x0 ≤ x < x0+SPRITE_SIZE & y0 ≤ y < y0+SPRITE_SIZE. Compute at COORD_W+1 bits so windows at the right or bottom edge do not wrap.
- Priority: the lowest-index hitting sprite wins. Only one ROM fetch per pixel.
- Address = img·SPRITE_SIZE² + (y−y0)·SPRITE_SIZE + (x−x0), truncated to MEM_ADDR_W. Address is 0 when nothing hits.
- Compose: the winner exists and `mem_data_i` ≠ TRANSPARENT_KEY → `RGB_o` = texel, `hit_o`=1. Otherwise `RGB_o` = delayed `bg_rgb_i`, `hit_o`=0. A transparent texel does not fall through to a lower-priority sprite.

## Timing
- Stage 1 (register): hit vector, winner, `mem_address_o`, bg, and winner-valid.
- Stage 2 (register): compose with `mem_data_i` and output `RGB_o`/`hit_o`.
- Latency is 2 clocks from coordinates to `RGB_o`, fully pipelined at one pixel per clock.
- Reset: all shadow/active registers, `mem_address_o`, `RGB_o`, `hit_o`, and pipeline valids = 0. All sprites are disabled.
- Reset mid-frame clears the pipeline immediately. Output is black until two clocks after release.
- Register changes never affect the frame in progress, only the frame following the next `frame_start_i`.

## Configuration
- `SPRITE_ANIM_EN` defined:
  - ctrl bits[11:8] = frame count F and bits[15:12] = frame divider D.
  - Per-sprite animation counter a advances on every D+1-th `frame_start_i`.
  - a wraps at F; F=0 means static. The counter resets to 0 on commit of a ctrl write.
  - Effective image = img + a.
- Undefined: ctrl bits[15:8] are ignored, no counters exist, image = img.

## Structure
- Package `sprite_pkg`: `sprite_regs_t` struct {x, y, en, img[, frames, div, anim]}, reg-select localparams, TRANSPARENT_KEY default.
- Sub-module `sprite_hit`: one instance per channel, with window compare and local offset outputs. The top level holds the priority encoder, address multiply-add, and pipeline.

## Test plan
- Reset, then scan 640×480 with bg=24'h000080 → `RGB_o`=24'h000080 with a 2-cycle lag, and `hit_o`=0 everywhere.
- Sprite0 x=50, y=70, img=1, enabled, then frame_start; scan (50,70) → `mem_address_o`=1024. Scan (81,101) → 2047. Scan (82,70) → no hit.
- Sprites 0 and 1 overlap at (60,80) → sprite0's address is used. With ROM returning TRANSPARENT_KEY there, output = bg and `hit_o`=0.
- Write x=200 mid-frame without frame_start → the old position persists. After the pulse, the new position is used. A write in the same cycle as the pulse is committed.
- Sprite at x=2040 (COORD_W=11) → no wrap hit at x=0..23.
- With `SPRITE_ANIM_EN`, F=3, D=0 → image cycles img, img+1, img+2, img across 4 frames.
